dmem_arbiter: RTL and testbench

- Shares the single-ported 512-word data memory between the pipeline MEM stage (port A) and the debug/loader port (port B).
- Converts byte addresses to word indices and range-checks them.
- Grants one access per cycle, with A priority bounded by a starvation counter.
- Registers read data with a fixed 1-cycle latency and produces the MEM-stage stall.

---
 rtl/dmem_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory: MEM stage (A) has
// priority, the debug/loader port (B) is forced ahead after STARVE_MAX denials.
module dmem_arbiter #(
    parameter int DEPTH_LOG2 = 9,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_read,
    input  logic                  a_write,
    input  logic [31:0]           a_addr,
    input  logic [31:0]           a_wdata,
    output logic [31:0]           a_rdata,
    output logic                  a_rvalid,
    output logic                  a_stall,
    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [31:0]           b_addr,
    input  logic [31:0]           b_wdata,
    output logic                  b_gnt,
    output logic [31:0]           b_rdata,
    output logic                  b_rvalid,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  addr_err
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

    owner_t           last_owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             a_req, b_req, a_ok, b_ok, a_gnt;

    function automatic logic addr_valid(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr[31:DEPTH_LOG2+2] == '0);
    endfunction

    assign a_req = a_read | a_write;
    assign b_req = b_read | b_write;
    assign a_ok  = addr_valid(a_addr);
    assign b_ok  = addr_valid(b_addr);

    // Grants are suppressed while reset is held so nothing reaches the memory.
    assign a_gnt   = !reset && a_req && (!b_req || starve_cnt != CNT_W'(STARVE_MAX));
    assign b_gnt   = !reset && b_req && !a_gnt;
    assign a_stall = !reset && a_req && !a_gnt;

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (a_gnt && a_ok) begin
            mem_read  = !a_write;
            mem_write = a_write;
            mem_addr  = a_addr[DEPTH_LOG2+1:2];
            mem_wdata = a_wdata;
        end else if (b_gnt && b_ok) begin
            mem_read  = !b_write;
            mem_write = b_write;
            mem_addr  = b_addr[DEPTH_LOG2+1:2];
            mem_wdata = b_wdata;
        end
    end

    // last_owner names the port whose read was granted last cycle; it is the rvalid.
    assign a_rvalid = (last_owner == OWN_A);
    assign b_rvalid = (last_owner == OWN_B);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_rdata    <= '0;
            b_rdata    <= '0;
            starve_cnt <= '0;
            addr_err   <= 1'b0;
            last_owner <= OWN_NONE;
        end else begin
            last_owner <= OWN_NONE;
            if (a_gnt && !a_write) begin
                last_owner <= OWN_A;
                a_rdata    <= a_ok ? mem_rdata : '0;
            end
            if (b_gnt && !b_write) begin
                last_owner <= OWN_B;
                b_rdata    <= b_ok ? mem_rdata : '0;
            end
            if ((a_gnt && !a_ok) || (b_gnt && !b_ok))
                addr_err <= 1'b1;
            if (b_req && a_gnt) begin
                if (starve_cnt != CNT_W'(STARVE_MAX))
                    starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 512-word data memory.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_read, a_write, a_rvalid, a_stall;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_read, b_write, b_gnt, b_rvalid;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        mem_read, mem_write, addr_err;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] mem_q [0:511];
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    dmem_arbiter #(.DEPTH_LOG2(9), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .a_read(a_read), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_rvalid(a_rvalid), .a_stall(a_stall),
        .b_read(b_read), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Data memory: write at the clock edge, asynchronous read.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) mem_q[i] <= 32'h0;
            mem_q[4] <= 32'hDEADBEEF;
        end else if (mem_write) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_q[mem_addr];

    task automatic idle();
        a_read = 0; a_write = 0; a_addr = 0; a_wdata = 0;
        b_read = 0; b_write = 0; b_addr = 0; b_wdata = 0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        a_read = 1; a_addr = 32'h10; b_write = 1; b_addr = 32'h20;
        mid();
        chk_cnt++; if (mem_read !== 1'b0) $display("FAIL rst_mem_read got %0b exp 0", mem_read); else pass_cnt++;
        chk_cnt++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write got %0b exp 0", mem_write); else pass_cnt++;
        chk_cnt++; if (a_stall !== 1'b0) $display("FAIL rst_a_stall got %0b exp 0", a_stall); else pass_cnt++;
        chk_cnt++; if (b_gnt !== 1'b0) $display("FAIL rst_b_gnt got %0b exp 0", b_gnt); else pass_cnt++;
        step();
        chk_cnt++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) $display("FAIL rst_rvalid got %0b%0b exp 00", a_rvalid, b_rvalid); else pass_cnt++;
        chk_cnt++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) $display("FAIL rst_rdata got %h/%h exp 0/0", a_rdata, b_rdata); else pass_cnt++;
        chk_cnt++; if (addr_err !== 1'b0) $display("FAIL rst_addr_err got %0b exp 0", addr_err); else pass_cnt++;
        idle(); reset = 0;
        step();
    endtask

    task automatic test_a_read();
        a_read = 1; a_addr = 32'h10;
        mid();
        chk_cnt++; if (mem_read !== 1'b1 || mem_write !== 1'b0) $display("FAIL rd_mem_ctl got r%0b w%0b exp r1 w0", mem_read, mem_write); else pass_cnt++;
        chk_cnt++; if (mem_addr !== 9'd4) $display("FAIL rd_mem_addr got %0d exp 4", mem_addr); else pass_cnt++;
        chk_cnt++; if (a_stall !== 1'b0) $display("FAIL rd_a_stall got %0b exp 0", a_stall); else pass_cnt++;
        step();
        idle();
        chk_cnt++; if (a_rvalid !== 1'b1) $display("FAIL rd_a_rvalid got %0b exp 1", a_rvalid); else pass_cnt++;
        chk_cnt++; if (a_rdata !== 32'hDEADBEEF) $display("FAIL rd_a_rdata got %h exp deadbeef", a_rdata); else pass_cnt++;
        chk_cnt++; if (b_rvalid !== 1'b0) $display("FAIL rd_b_rvalid got %0b exp 0", b_rvalid); else pass_cnt++;
        step();
        chk_cnt++; if (a_rvalid !== 1'b0) $display("FAIL rd_a_rvalid_drop got %0b exp 0", a_rvalid); else pass_cnt++;
        chk_cnt++; if (a_rdata !== 32'hDEADBEEF) $display("FAIL rd_a_rdata_hold got %h exp deadbeef", a_rdata); else pass_cnt++;
    endtask

    task automatic test_raw();
        a_write = 1; a_addr = 32'h40; a_wdata = 32'h12345678;
        mid();
        chk_cnt++; if (mem_write !== 1'b1 || mem_read !== 1'b0) $display("FAIL raw_wr_ctl got w%0b r%0b exp w1 r0", mem_write, mem_read); else pass_cnt++;
        chk_cnt++; if (mem_addr !== 9'd16) $display("FAIL raw_wr_addr got %0d exp 16", mem_addr); else pass_cnt++;
        chk_cnt++; if (mem_wdata !== 32'h12345678) $display("FAIL raw_wr_data got %h exp 12345678", mem_wdata); else pass_cnt++;
        step();
        chk_cnt++; if (a_rvalid !== 1'b0) $display("FAIL raw_wr_no_rvalid got %0b exp 0", a_rvalid); else pass_cnt++;
        a_write = 0; a_read = 1;
        mid();
        chk_cnt++; if (mem_read !== 1'b1 || mem_addr !== 9'd16) $display("FAIL raw_rd_ctl got r%0b a%0d exp r1 a16", mem_read, mem_addr); else pass_cnt++;
        step();
        idle();
        chk_cnt++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h12345678) $display("FAIL raw_rd_data got v%0b %h exp v1 12345678", a_rvalid, a_rdata); else pass_cnt++;
        chk_cnt++; if (b_rdata !== 32'h0) $display("FAIL raw_b_rdata_hold got %h exp 0", b_rdata); else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        b_read = 1; b_addr = 32'h10;
        mid();
        chk_cnt++; if (b_gnt !== 1'b1) $display("FAIL b2b_gnt0 got %0b exp 1", b_gnt); else pass_cnt++;
        step();
        b_addr = 32'h40;
        chk_cnt++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hDEADBEEF) $display("FAIL b2b_rd0 got v%0b %h exp v1 deadbeef", b_rvalid, b_rdata); else pass_cnt++;
        mid();
        chk_cnt++; if (b_gnt !== 1'b1 || mem_addr !== 9'd16) $display("FAIL b2b_gnt1 got g%0b a%0d exp g1 a16", b_gnt, mem_addr); else pass_cnt++;
        step();
        idle();
        chk_cnt++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h12345678) $display("FAIL b2b_rd1 got v%0b %h exp v1 12345678", b_rvalid, b_rdata); else pass_cnt++;
        chk_cnt++; if (a_rvalid !== 1'b0 || a_rdata !== 32'h12345678) $display("FAIL b2b_a_hold got v%0b %h exp v0 12345678", a_rvalid, a_rdata); else pass_cnt++;
        step();
        chk_cnt++; if (b_rvalid !== 1'b0) $display("FAIL b2b_rvalid_drop got %0b exp 0", b_rvalid); else pass_cnt++;
    endtask

    task automatic test_starve();
        a_read = 1; a_addr = 32'h40; b_read = 1; b_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            mid();
            chk_cnt++; if (b_gnt !== (i % 5 == 4)) $display("FAIL starve_b_gnt cyc%0d got %0b exp %0b", i, b_gnt, (i % 5 == 4)); else pass_cnt++;
            chk_cnt++; if (a_stall !== (i % 5 == 4)) $display("FAIL starve_a_stall cyc%0d got %0b exp %0b", i, a_stall, (i % 5 == 4)); else pass_cnt++;
            step();
        end
        idle();
        chk_cnt++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hDEADBEEF) $display("FAIL starve_b_rd got v%0b %h exp v1 deadbeef", b_rvalid, b_rdata); else pass_cnt++;
        step();
    endtask

    task automatic test_addr_err();
        b_write = 1; b_addr = 32'h802; b_wdata = 32'hCAFEF00D;
        mid();
        chk_cnt++; if (b_gnt !== 1'b1 || mem_write !== 1'b0) $display("FAIL err_b_wr got g%0b w%0b exp g1 w0", b_gnt, mem_write); else pass_cnt++;
        step();
        idle();
        chk_cnt++; if (addr_err !== 1'b1) $display("FAIL err_sticky0 got %0b exp 1", addr_err); else pass_cnt++;
        a_read = 1; a_addr = 32'h800;
        mid();
        chk_cnt++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || a_stall !== 1'b0) $display("FAIL err_a_rd got r%0b w%0b s%0b exp 000", mem_read, mem_write, a_stall); else pass_cnt++;
        step();
        idle();
        chk_cnt++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) $display("FAIL err_a_rdata got v%0b %h exp v1 0", a_rvalid, a_rdata); else pass_cnt++;
        step();
        chk_cnt++; if (addr_err !== 1'b1) $display("FAIL err_sticky1 got %0b exp 1", addr_err); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        a_read = 1; a_addr = 32'h10; b_read = 1; b_addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk_cnt++; if (b_gnt !== 1'b0) $display("FAIL rmid_pre_gnt cyc%0d got %0b exp 0", i, b_gnt); else pass_cnt++;
            step();
        end
        idle(); reset = 1;
        chk_cnt++; if (a_rvalid !== 1'b1) $display("FAIL rmid_pre_rvalid got %0b exp 1", a_rvalid); else pass_cnt++;
        step();
        chk_cnt++; if (a_rvalid !== 1'b0 || a_rdata !== 32'h0) $display("FAIL rmid_a got v%0b %h exp v0 0", a_rvalid, a_rdata); else pass_cnt++;
        chk_cnt++; if (b_rdata !== 32'h0 || addr_err !== 1'b0) $display("FAIL rmid_b_err got %h e%0b exp 0 e0", b_rdata, addr_err); else pass_cnt++;
        reset = 0;
        a_read = 1; a_addr = 32'h10; b_read = 1; b_addr = 32'h10;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk_cnt++; if (b_gnt !== (i == 4)) $display("FAIL rmid_starve cyc%0d got %0b exp %0b", i, b_gnt, (i == 4)); else pass_cnt++;
            step();
        end
        idle();
        step();
    endtask

    task automatic test_rw_both();
        a_read = 1; a_write = 1; a_addr = 32'h8; a_wdata = 32'hA5A5A5A5;
        mid();
        chk_cnt++; if (mem_write !== 1'b1 || mem_read !== 1'b0) $display("FAIL rw_ctl got w%0b r%0b exp w1 r0", mem_write, mem_read); else pass_cnt++;
        chk_cnt++; if (mem_addr !== 9'd2 || mem_wdata !== 32'hA5A5A5A5) $display("FAIL rw_bus got a%0d %h exp a2 a5a5a5a5", mem_addr, mem_wdata); else pass_cnt++;
        step();
        idle();
        chk_cnt++; if (a_rvalid !== 1'b0) $display("FAIL rw_no_rvalid got %0b exp 0", a_rvalid); else pass_cnt++;
        chk_cnt++; if (mem_q[2] !== 32'hA5A5A5A5) $display("FAIL rw_mem got %h exp a5a5a5a5", mem_q[2]); else pass_cnt++;
        step();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_a_read();
        test_raw();
        test_back_to_back();
        test_starve();
        test_addr_err();
        test_reset_mid();
        test_rw_both();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
